dac_pwm_driver: RTL and testbench

DAC_PWM_DRIVER -- requirements
Module: dac_pwm_driver

---
 rtl/dac_pwm_driver.sv | 189 ++++++++++++++++++
 tb/tb_dac_pwm_driver.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dac_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module   : dac_pwm_driver
// Purpose  : Converts the FLL control-loop DAC code into a 1-bit PWM or
//            first-order delta-sigma stream for the analog filter, and applies
//            the VCO corner select with a blanking interval after each change.
// Revision : 1.0  initial release
// ============================================================================
module dac_pwm_driver #(
   parameter int N      = 10,   // code width; modulation period is 2^N cycles
   parameter int SETTLE = 16    // blanking cycles after a corner change (1..255)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable,
   input  logic         mode,
   input  logic [N-1:0] dac,
   input  logic [2:0]   corner,
   output logic         pwm_out,
   output logic [2:0]   corner_out,
   output logic         period_strobe,
   output logic [N-1:0] active_code,
   output logic         busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_SETTLE = 2'd2
   } state_t;

   localparam logic [N-1:0] c_CNT_MAX   = '1;
   localparam logic [N-1:0] c_CNT_ONE   = N'(1);
   localparam logic [7:0]   c_SCNT_LOAD = 8'(SETTLE - 1);

   // Registered state
   state_t       r_state;
   logic [N-1:0] r_cnt;
   logic [N-1:0] r_acc;
   logic [7:0]   r_scnt;
   logic         r_mode;
   logic [N-1:0] r_code;
   logic [2:0]   r_corner;
   logic         r_pwm;
   logic         r_strobe;
   logic         r_busy;

   // Next-state values
   state_t       w_state_nxt;
   logic [N-1:0] w_cnt_nxt;
   logic [N-1:0] w_acc_nxt;
   logic [7:0]   w_scnt_nxt;
   logic         w_mode_nxt;
   logic [N-1:0] w_code_nxt;
   logic [2:0]   w_corner_nxt;
   logic         w_pwm_nxt;
   logic         w_strobe_nxt;
   logic         w_busy_nxt;

   // Helpers
   logic [N:0]   w_sum;
   logic         w_corner_chg;
   logic         w_wrap;

   assign w_sum        = {1'b0, r_acc} + {1'b0, r_code};
   assign w_corner_chg = (corner != r_corner);
   assign w_wrap       = (r_cnt == c_CNT_MAX);

   // Next-state and next-output decode; priority is disable > corner change > wrap
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_acc_nxt    = r_acc;
      w_scnt_nxt   = r_scnt;
      w_mode_nxt   = r_mode;
      w_code_nxt   = r_code;
      w_corner_nxt = r_corner;
      w_pwm_nxt    = 1'b0;
      w_busy_nxt   = 1'b0;
      w_strobe_nxt = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            w_acc_nxt = '0;
            if (enable) begin
               w_code_nxt   = dac;
               w_corner_nxt = corner;
               w_mode_nxt   = mode;
               w_state_nxt  = ST_RUN;
            end
         end

         ST_RUN: begin
            if (!enable) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
               w_acc_nxt   = '0;
            end else if (w_corner_chg) begin
               w_corner_nxt = corner;
               w_scnt_nxt   = c_SCNT_LOAD;
               w_busy_nxt   = 1'b1;
               w_cnt_nxt    = '0;
               w_state_nxt  = ST_SETTLE;
            end else begin
               // Counter wraps naturally from all-ones to zero
               w_cnt_nxt = r_cnt + c_CNT_ONE;
               if (r_mode) begin
                  w_pwm_nxt = w_sum[N];
                  w_acc_nxt = w_sum[N-1:0];
               end else begin
                  w_pwm_nxt = (r_cnt < r_code);
               end
               // New code and mode only take effect on a period boundary
               if (w_wrap) begin
                  w_code_nxt = dac;
                  w_mode_nxt = mode;
               end
            end
         end

         ST_SETTLE: begin
            if (!enable) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
               w_acc_nxt   = '0;
            end else if (w_corner_chg) begin
               // Another corner change restarts the blanking interval
               w_corner_nxt = corner;
               w_scnt_nxt   = c_SCNT_LOAD;
               w_busy_nxt   = 1'b1;
            end else if (r_scnt == 8'd0) begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = '0;
               w_acc_nxt   = '0;
               w_code_nxt  = dac;
               w_mode_nxt  = mode;
            end else begin
               w_scnt_nxt = r_scnt - 8'd1;
               w_busy_nxt = 1'b1;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_acc_nxt   = '0;
         end
      endcase

      // Strobe is registered, so it is raised on the edge entering the last count
      w_strobe_nxt = (w_state_nxt == ST_RUN) && (w_cnt_nxt == c_CNT_MAX);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_scnt   <= 8'd0;
         r_mode   <= 1'b0;
         r_code   <= '0;
         r_corner <= 3'd0;
         r_pwm    <= 1'b0;
         r_strobe <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_acc    <= w_acc_nxt;
         r_scnt   <= w_scnt_nxt;
         r_mode   <= w_mode_nxt;
         r_code   <= w_code_nxt;
         r_corner <= w_corner_nxt;
         r_pwm    <= w_pwm_nxt;
         r_strobe <= w_strobe_nxt;
         r_busy   <= w_busy_nxt;
      end
   end

   assign pwm_out       = r_pwm;
   assign corner_out    = r_corner;
   assign period_strobe = r_strobe;
   assign active_code   = r_code;
   assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dac_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_pwm_driver
// Purpose  : Directed self-checking bench for dac_pwm_driver (N=10, SETTLE=16).
//            Outputs are sampled 1 time unit after each rising edge; inputs
//            are driven right after sampling. After a tick, the observed
//            RUN cycle has cnt equal to the tick index modulo 1024.
// Revision : 1.0  initial release
// ============================================================================
module tb_dac_pwm_driver;

   localparam int N = 10;
   localparam int P = 1024;

   logic         clk = 1'b0;
   logic         reset;
   logic         enable;
   logic         mode;
   logic [N-1:0] dac;
   logic [2:0]   corner;
   logic         pwm_out;
   logic [2:0]   corner_out;
   logic         period_strobe;
   logic [N-1:0] active_code;
   logic         busy;

   int n_checks = 0;
   int n_errors = 0;

   dac_pwm_driver #(.N(N), .SETTLE(16)) u_dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .mode          (mode),
      .dac           (dac),
      .corner        (corner),
      .pwm_out       (pwm_out),
      .corner_out    (corner_out),
      .period_strobe (period_strobe),
      .active_code   (active_code),
      .busy          (busy)
   );

   // 10-unit clock period
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run n cycles, gathering pwm/strobe statistics
   task automatic window(input int n, output int highs, output int strobes,
                         output int last_strobe, output int changes);
      logic prev;
      highs = 0; strobes = 0; last_strobe = -1; changes = 0; prev = 1'b0;
      for (int i = 1; i <= n; i++) begin
         tick();
         highs += int'(pwm_out);
         if (period_strobe) begin
            strobes++;
            last_strobe = i;
         end
         if (i > 1 && pwm_out != prev) changes++;
         prev = pwm_out;
      end
   endtask

   // Count busy observations (starting at one already showing busy);
   // optionally change corner after chg_at busy observations
   task automatic count_busy(input int chg_at, input logic [2:0] chg_val,
                             output int nb, output int nhi);
      nb = 0; nhi = 0;
      for (int g = 0; g < 200; g++) begin
         if (!busy) return;
         nb++;
         nhi += int'(pwm_out);
         if (nb == chg_at) corner = chg_val;
         tick();
      end
      chk("busy_timeout", 1, 0);
   endtask

   initial begin
      int h, s, ls, ch, nb, nhi;

      // Reset state
      reset = 1'b1; enable = 1'b0; mode = 1'b0; dac = '0; corner = 3'd0;
      tick(); tick();
      chk("rst_pwm", int'(pwm_out), 0);
      chk("rst_corner", int'(corner_out), 0);
      chk("rst_strobe", int'(period_strobe), 0);
      chk("rst_code", int'(active_code), 0);
      chk("rst_busy", int'(busy), 0);

      // Stays idle after reset release until enable
      reset = 1'b0; dac = 10'd256; corner = 3'd3;
      tick(); tick();
      chk("idle_hold_corner", int'(corner_out), 0);
      chk("idle_hold_code", int'(active_code), 0);

      // PWM duty 256/1024
      enable = 1'b1;
      tick();
      chk("en_corner", int'(corner_out), 3);
      chk("en_code", int'(active_code), 256);
      chk("en_pwm", int'(pwm_out), 0);
      window(P, h, s, ls, ch);
      chk("pwm256_highs", h, 256);
      chk("pwm256_strobes", s, 1);
      chk("pwm256_strobe_pos", ls, 1023);

      // Extremes: code 0 then code 1023
      dac = 10'd0;
      window(P, h, s, ls, ch);
      chk("code0_loaded", int'(active_code), 0);
      window(P, h, s, ls, ch);
      chk("pwm0_highs", h, 0);
      dac = 10'd1023;
      window(P, h, s, ls, ch);
      chk("code1023_loaded", int'(active_code), 1023);
      window(P, h, s, ls, ch);
      chk("pwm1023_highs", h, 1023);

      // Mid-period update 256 -> 768 at cnt=100
      dac = 10'd256;
      window(P, h, s, ls, ch);
      h = 0;
      for (int i = 1; i <= P; i++) begin
         tick();
         h += int'(pwm_out);
         if (i == 100) dac = 10'd768;
         if (i == 1023) begin
            chk("mid_strobe", int'(period_strobe), 1);
            chk("mid_code_before", int'(active_code), 256);
         end
      end
      chk("mid_code_after", int'(active_code), 768);
      chk("mid_cur_highs", h, 256);
      window(P, h, s, ls, ch);
      chk("mid_next_highs", h, 768);

      // Corner change 3 -> 5 in RUN
      corner = 3'd5;
      tick();
      chk("cc_corner", int'(corner_out), 5);
      chk("cc_busy", int'(busy), 1);
      chk("cc_pwm", int'(pwm_out), 0);
      count_busy(0, 3'd0, nb, nhi);
      chk("cc_busy_cycles", nb, 16);
      chk("cc_blank_pwm", nhi, 0);
      window(P, h, s, ls, ch);
      chk("cc_run_highs", h, 768);
      chk("cc_run_strobe_pos", ls, 1023);

      // Second change 8 cycles into settle restarts blanking
      corner = 3'd6;
      tick();
      count_busy(8, 3'd2, nb, nhi);
      chk("cc2_busy_cycles", nb, 24);
      chk("cc2_corner", int'(corner_out), 2);

      // Delta-sigma, code 512 then code 1
      mode = 1'b1; dac = 10'd512;
      window(P, h, s, ls, ch);
      window(P, h, s, ls, ch);
      chk("ds512_ones", h, 512);
      chk("ds512_toggles", ch, 1023);
      dac = 10'd1;
      window(P, h, s, ls, ch);
      window(P, h, s, ls, ch);
      chk("ds1_ones", h, 1);

      // Corner change on the wrap cycle
      window(P - 1, h, s, ls, ch);
      chk("wrapcc_strobe", int'(period_strobe), 1);
      corner = 3'd1;
      tick();
      chk("wrapcc_busy", int'(busy), 1);
      chk("wrapcc_strobe_after", int'(period_strobe), 0);
      chk("wrapcc_corner", int'(corner_out), 1);

      // Reset during SETTLE
      tick(); tick(); tick();
      reset = 1'b1;
      tick();
      chk("rs_pwm", int'(pwm_out), 0);
      chk("rs_corner", int'(corner_out), 0);
      chk("rs_busy", int'(busy), 0);
      chk("rs_code", int'(active_code), 0);
      chk("rs_strobe", int'(period_strobe), 0);

      // Restart in PWM mode, then disable mid-RUN
      reset = 1'b0; mode = 1'b0; dac = 10'd300; corner = 3'd4;
      tick();
      chk("re_corner", int'(corner_out), 4);
      chk("re_code", int'(active_code), 300);
      window(50, h, s, ls, ch);
      chk("re_pwm_high", int'(pwm_out), 1);
      enable = 1'b0;
      tick();
      chk("dis_pwm", int'(pwm_out), 0);
      chk("dis_busy", int'(busy), 0);
      chk("dis_corner", int'(corner_out), 4);
      window(20, h, s, ls, ch);
      chk("dis_quiet", h + s, 0);
      chk("dis_code_held", int'(active_code), 300);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
